dqs_gate_cal: RTL
=================

DQS_GATE_CAL -- requirements
Module: dqs_gate_cal

Interface
REQ-001 Parameter NUM_LANES, default 2: number of DQS lanes calibrated in parallel (1..8).
REQ-002 Parameter DLY_W, default 8: delay tap code width; the sweep covers taps 0..2^DLY_W-1.
REQ-003 Parameter SETTLE_CYC, default 4: cycles to wait after each tap load before sampling (1..255).
REQ-004 Parameter SAMPLE_CNT, default 16: samples taken per tap (1..255).
REQ-005 One clock; reset is asynchronous and active-high: port sclk, input, 1, system clock; all logic is on its rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 start  input  1  single-cycle request to begin a calibration sweep.
REQ-008 dqs_sample  input  NUM_LANES  per-lane gated-DQS sample; 1 means pass.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  high from sweep completion until the next accepted start.
REQ-011 fail  output  NUM_LANES  per-lane flag: no passing tap was found; valid while done=1.
REQ-012 pause  output  1  freezes the DQS buffer while taps change, like the DQSBUF PAUSE pin.
REQ-013 dly_load  output  1  single-cycle strobe: dly_val is to be applied.
REQ-014 dly_val  output  NUM_LANES*DLY_W  per-lane tap code; lane n occupies bits [n*DLY_W +: DLY_W].

Function
REQ-015 The FSM states SHALL be IDLE, LOAD, SETTLE, SAMPLE, EVAL, APPLY and DONE.
REQ-016 IDLE/DONE with start=1 -> LOAD the next cycle: tap=0, all lane trackers cleared, done=0, busy=1.
REQ-017 start SHALL be ignored while busy=1.
REQ-018 LOAD: 1 cycle; dly_load=1, every lane's dly_val=tap, pause=1 -> SETTLE.
REQ-019 SETTLE: exactly SETTLE_CYC cycles with pause=1 -> SAMPLE.
REQ-020 SAMPLE: exactly SAMPLE_CNT cycles, pause=0; a lane passes this tap only if dqs_sample was 1 on every sampled cycle.
REQ-021 EVAL: 1 cycle updates each lane tracker; if tap=2^DLY_W-1 -> APPLY, else tap+1 -> LOAD.
REQ-022 Per-tap period SHALL be 2+SETTLE_CYC+SAMPLE_CNT cycles; the tap SHALL NOT wrap.
REQ-023 Lane tracker: first passing tap sets lo=hi=tap and opens the window; further contiguous passes set hi=tap; the first fail after opening closes the window; later passes are ignored (first window wins).
REQ-024 A window still open at the last tap SHALL close with hi=2^DLY_W-1.
REQ-025 APPLY: 1 cycle; dly_load=1, pause=1, lane dly_val=(lo+hi)>>1 computed in DLY_W+1 bits (floor); a lane with no window gets 0 and fail=1 -> DONE.
REQ-026 DONE: busy=0, done=1, pause=0; dly_val and fail hold until the next accepted start.
REQ-027 dly_load SHALL be high only in LOAD and APPLY.

Reset
REQ-028 On rst: state=IDLE; busy, done, pause and dly_load=0; fail=0; dly_val=0; tap=0; trackers cleared.
REQ-029 rst asserted mid-sweep SHALL abort immediately; no APPLY is issued.
REQ-030 The first start after rst deasserts SHALL be accepted on the first rising edge with rst low.

Structure
REQ-031 Package dqs_cal_pkg SHALL hold the state enum and the tracker result struct (lo, hi, found, closed).
REQ-032 One sub-module, dqs_cal_lane, instantiated NUM_LANES times, SHALL hold the sample AND-accumulator, the window tracker and the midpoint computation.

Verification (DLY_W=4, SETTLE_CYC=2, SAMPLE_CNT=4, NUM_LANES=2; 8-cycle tap period)
REQ-033 Lane0 passes taps 5..9, lane1 passes 3..12 -> dly_val lane0=7, lane1=7; fail=00; done asserted 130 cycles after start (16 taps*8+APPLY+1).
REQ-034 Lane0 never passes, lane1 passes only tap 15 -> fail=01 (lane0), lane0=0, lane1=15.
REQ-035 Lane0 passes 2..3 and 8..12 -> lane0=2 (first window only).
REQ-036 Lane1 passes 4..6 except one 0 sample at tap 5 -> tap 5 fails; window 4..4 -> lane1=4.
REQ-037 Assert rst during tap 7 SAMPLE -> next cycle busy=0, done=0, dly_val=0, no dly_load; a new start gives a full clean sweep.
REQ-038 Pulse start at tap 3 of a running sweep -> no effect; pause high in exactly LOAD+SETTLE+APPLY cycles.

Source files
------------

// File: rtl/dqs_cal_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dqs_cal_pkg
// Description : Shared types for the DQS gate calibration block. Contains the
//               sweep FSM state encoding, the per-lane window tracker record
//               and the window midpoint helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package dqs_cal_pkg;

   // Widest tap code the tracker record can hold. Lanes zero-extend their
   // DLY_W-bit tap into these fields.
   localparam int DLY_W_MAX = 16;

   // Width of the settle/sample cycle counter (both lengths are 1..255).
   localparam int CNT_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_EVAL   = 3'd4,
      ST_APPLY  = 3'd5,
      ST_DONE   = 3'd6
   } cal_state_e;

   // Passing-window tracker for one lane. found marks that a window has
   // opened; closed marks that it has ended and later passes are ignored.
   typedef struct packed {
      logic [DLY_W_MAX-1:0] lo;
      logic [DLY_W_MAX-1:0] hi;
      logic                 found;
      logic                 closed;
   } win_trk_t;

   // floor((lo + hi) / 2) with one guard bit so the sum cannot overflow.
   function automatic logic [DLY_W_MAX-1:0] win_mid(
      input logic [DLY_W_MAX-1:0] lo,
      input logic [DLY_W_MAX-1:0] hi
   );
      logic [DLY_W_MAX:0] sum;
      sum = {1'b0, lo} + {1'b0, hi};
      return DLY_W_MAX'(sum >> 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dqs_cal_lane.sv
`default_nettype none
// ============================================================================
// Module      : dqs_cal_lane
// Description : One DQS lane of the gate calibration sweep. ANDs the gated
//               DQS samples taken at the current tap, tracks the first
//               contiguous passing window and produces the window midpoint.
// Ports       : sclk      - system clock, rising edge
//               rst       - asynchronous active-high reset
//               clear     - sweep accepted: clear tracker and held result
//               acc_init  - tap load cycle: re-arm the sample accumulator
//               sample_en - sample cycle: fold sample into the accumulator
//               sample    - gated DQS sample, 1 = pass
//               eval      - evaluation cycle: update the window tracker
//               last_tap  - current tap is the final tap of the sweep
//               apply     - apply cycle: capture midpoint and fail flag
//               tap       - tap code currently under test
//               mid_val   - midpoint of the tracked window (0 if none)
//               res_val   - held calibration result
//               res_fail  - held flag: no passing tap was found
// Revision    : 1.0 - initial release
// ============================================================================
module dqs_cal_lane
   import dqs_cal_pkg::*;
#(
   parameter int DLY_W = 8
) (
   input  logic             sclk,
   input  logic             rst,
   input  logic             clear,
   input  logic             acc_init,
   input  logic             sample_en,
   input  logic             sample,
   input  logic             eval,
   input  logic             last_tap,
   input  logic             apply,
   input  logic [DLY_W-1:0] tap,
   output logic [DLY_W-1:0] mid_val,
   output logic [DLY_W-1:0] res_val,
   output logic             res_fail
);

   logic                 acc;
   win_trk_t             trk;
   win_trk_t             trk_nxt;
   logic [DLY_W_MAX-1:0] tap_ext;
   logic [DLY_W_MAX-1:0] mid_full;

   always_comb begin
      tap_ext            = '0;
      tap_ext[DLY_W-1:0] = tap;
   end

   // Window tracker: the first pass opens the window, contiguous passes
   // extend it, the first fail closes it. Once closed nothing changes, so
   // only the first window ever counts.
   always_comb begin
      trk_nxt = trk;
      if (!trk.closed) begin
         if (acc) begin
            if (!trk.found) begin
               trk_nxt.lo    = tap_ext;
               trk_nxt.found = 1'b1;
            end
            trk_nxt.hi = tap_ext;
         end else if (trk.found) begin
            trk_nxt.closed = 1'b1;
         end
         // A window still open at the final tap ends there; hi already
         // equals the final tap because that tap passed.
         if (last_tap && trk_nxt.found) begin
            trk_nxt.closed = 1'b1;
         end
      end
   end

   assign mid_full = win_mid(trk.lo, trk.hi);
   assign mid_val  = trk.found ? mid_full[DLY_W-1:0] : '0;

   generate
      if (DLY_W < DLY_W_MAX) begin : g_mid_pad
         // Bits above DLY_W are always zero because lo/hi < 2^DLY_W.
         logic unused_mid_hi;
         assign unused_mid_hi = ^mid_full[DLY_W_MAX-1:DLY_W];
      end
   endgenerate

   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         acc      <= 1'b0;
         trk      <= '0;
         res_val  <= '0;
         res_fail <= 1'b0;
      end else begin
         if (acc_init) begin
            acc <= 1'b1;
         end else if (sample_en) begin
            acc <= acc & sample;
         end

         if (clear) begin
            trk <= '0;
         end else if (eval) begin
            trk <= trk_nxt;
         end

         if (clear) begin
            res_val  <= '0;
            res_fail <= 1'b0;
         end else if (apply) begin
            res_val  <= mid_val;
            res_fail <= ~trk.found;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/dqs_gate_cal.sv
`default_nettype none
// ============================================================================
// Module      : dqs_gate_cal
// Description : DQS gate calibration. Sweeps the DQS delay tap from 0 to
//               2^DLY_W-1 on all lanes in parallel; for each tap it loads the
//               code, waits SETTLE_CYC cycles with the buffer paused, then
//               takes SAMPLE_CNT samples. Each lane keeps its first passing
//               window and is finally set to the window midpoint.
// Ports       : sclk       - system clock, rising edge
//               rst        - asynchronous active-high reset
//               start      - single-cycle sweep request (ignored while busy)
//               dqs_sample - per-lane gated DQS sample, 1 = pass
//               busy       - sweep in progress
//               done       - sweep finished, results valid
//               fail       - per-lane: no passing tap found (valid with done)
//               pause      - freeze the DQS buffer while taps change
//               dly_load   - strobe: apply dly_val
//               dly_val    - per-lane tap code, lane n at [n*DLY_W +: DLY_W]
// Revision    : 1.0 - initial release
// ============================================================================
module dqs_gate_cal
   import dqs_cal_pkg::*;
#(
   parameter int NUM_LANES  = 2,
   parameter int DLY_W      = 8,
   parameter int SETTLE_CYC = 4,
   parameter int SAMPLE_CNT = 16
) (
   input  logic                       sclk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [NUM_LANES-1:0]       dqs_sample,
   output logic                       busy,
   output logic                       done,
   output logic [NUM_LANES-1:0]       fail,
   output logic                       pause,
   output logic                       dly_load,
   output logic [NUM_LANES*DLY_W-1:0] dly_val
);

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CNT - 1);
   localparam logic [DLY_W-1:0] TAP_LAST    = '1;

   cal_state_e                 state;
   cal_state_e                 state_nxt;
   logic [CNT_W-1:0]           cnt;
   logic [DLY_W-1:0]           tap;
   logic                       start_acc;
   logic                       last_tap;
   logic [NUM_LANES*DLY_W-1:0] mid_all;
   logic [NUM_LANES*DLY_W-1:0] res_all;

   // start is only honoured when no sweep is running.
   assign start_acc = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign last_tap  = (tap == TAP_LAST);

   // ---------------------------------------------------------------- state
   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE,
         ST_DONE:   if (start) state_nxt = ST_LOAD;
         ST_LOAD:   state_nxt = ST_SETTLE;
         ST_SETTLE: if (cnt == SETTLE_LAST) state_nxt = ST_SAMPLE;
         ST_SAMPLE: if (cnt == SAMPLE_LAST) state_nxt = ST_EVAL;
         ST_EVAL:   state_nxt = last_tap ? ST_APPLY : ST_LOAD;
         ST_APPLY:  state_nxt = ST_DONE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      busy     = 1'b0;
      done     = 1'b0;
      pause    = 1'b0;
      dly_load = 1'b0;
      dly_val  = res_all;
      case (state)
         ST_LOAD: begin
            busy     = 1'b1;
            pause    = 1'b1;
            dly_load = 1'b1;
            dly_val  = {NUM_LANES{tap}};
         end
         ST_SETTLE: begin
            busy    = 1'b1;
            pause   = 1'b1;
            dly_val = {NUM_LANES{tap}};
         end
         ST_SAMPLE,
         ST_EVAL: begin
            busy    = 1'b1;
            dly_val = {NUM_LANES{tap}};
         end
         ST_APPLY: begin
            busy     = 1'b1;
            pause    = 1'b1;
            dly_load = 1'b1;
            dly_val  = mid_all;
         end
         ST_DONE: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------- cycle counter / tap
   // cnt restarts on every state change, so it counts cycles spent in the
   // current state; only SETTLE and SAMPLE look at it.
   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         tap <= '0;
      end else begin
         if (state_nxt != state) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end

         if (start_acc) begin
            tap <= '0;
         end else if ((state == ST_EVAL) && !last_tap) begin
            tap <= tap + DLY_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------- lanes
   generate
      for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
         dqs_cal_lane #(
            .DLY_W (DLY_W)
         ) u_lane (
            .sclk      (sclk),
            .rst       (rst),
            .clear     (start_acc),
            .acc_init  (state == ST_LOAD),
            .sample_en (state == ST_SAMPLE),
            .sample    (dqs_sample[n]),
            .eval      (state == ST_EVAL),
            .last_tap  (last_tap),
            .apply     (state == ST_APPLY),
            .tap       (tap),
            .mid_val   (mid_all[n*DLY_W +: DLY_W]),
            .res_val   (res_all[n*DLY_W +: DLY_W]),
            .res_fail  (fail[n])
         );
      end
   endgenerate

endmodule
`default_nettype wire
